// File: rtl/alarm_ctrl_if.sv
// Button/tick inputs and time/alarm display outputs of the alarm clock controller.
interface alarm_ctrl_if;
   logic       Tick1Hz;
   logic       BtnSet;
   logic       BtnAlarm;
   logic       BtnInc;
   logic       BtnStop;
   logic [4:0] Hour;
   logic [5:0] Min;
   logic [5:0] Sec;
   logic [4:0] AlHour;
   logic [5:0] AlMin;
   logic       AlarmOn;
   logic       Ringing;
   logic [2:0] State;

   modport master (
      output Tick1Hz, BtnSet, BtnAlarm, BtnInc, BtnStop,
      input  Hour, Min, Sec, AlHour, AlMin, AlarmOn, Ringing, State
   );

   modport slave (
      input  Tick1Hz, BtnSet, BtnAlarm, BtnInc, BtnStop,
      output Hour, Min, Sec, AlHour, AlMin, AlarmOn, Ringing, State
   );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: 24h timekeeping, time/alarm setting, ring and auto-stop.
// Optional snooze state is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_ctrl #(
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300
) (
   input logic         Clk,
   input logic         Rst_n,
   alarm_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      AL_H   = 3'd3,
      AL_M   = 3'd4,
      RING   = 3'd5,
      SNOOZE = 3'd6
   } state_t;

   if (RING_SECS < 1 || RING_SECS > 511 || SNOOZE_SECS < 1 || SNOOZE_SECS > 511) begin : g_bad_param
      $error("alarm_ctrl: RING_SECS and SNOOZE_SECS must be in 1..511");
   end

   localparam logic [8:0] RING_CNT = 9'(RING_SECS);
`ifdef ALARM_SNOOZE_EN
   localparam logic [8:0] SNOOZE_CNT = 9'(SNOOZE_SECS);
`endif

   state_t     state_q;
   logic [4:0] hour_q, al_hour_q;
   logic [5:0] min_q, sec_q, al_min_q;
   logic       al_on_q, ring_q;
   logic [8:0] sec_cnt_q;

   logic [4:0] hour_d;
   logic [5:0] min_d, sec_d;
   logic [8:0] cnt_d;
   logic       match;

   // Time as it would read after one tick; applied only when Tick1Hz is high.
   always_comb begin
      hour_d = hour_q;
      min_d  = min_q;
      sec_d  = sec_q + 6'd1;
      if (sec_q == 6'd59) begin
         sec_d = '0;
         min_d = min_q + 6'd1;
         if (min_q == 6'd59) begin
            min_d  = '0;
            hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
         end
      end
      match = al_on_q && (hour_d == al_hour_q) && (min_d == al_min_q) && (sec_d == '0);
      cnt_d = sec_cnt_q + 9'd1;
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= RUN;
         hour_q    <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         al_hour_q <= '0;
         al_min_q  <= '0;
         al_on_q   <= 1'b0;
         ring_q    <= 1'b0;
         sec_cnt_q <= '0;
      end else begin
         // Clock keeps running everywhere except the two time-set states.
         if (bus.Tick1Hz && state_q != SET_H && state_q != SET_M) begin
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
         end
         case (state_q)
            RUN: begin
               if (bus.Tick1Hz && match) begin
                  state_q   <= RING;
                  ring_q    <= 1'b1;
                  sec_cnt_q <= '0;
               end else if (bus.BtnSet) begin
                  state_q <= SET_H;
               end else if (bus.BtnAlarm) begin
                  state_q <= AL_H;
               end else if (bus.BtnStop) begin
                  al_on_q <= ~al_on_q;
               end
            end
            SET_H: begin
               if (bus.BtnInc) hour_q <= (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
               if (bus.BtnSet) state_q <= SET_M;
            end
            SET_M: begin
               if (bus.BtnInc) min_q <= (min_q == 6'd59) ? '0 : min_q + 6'd1;
               if (bus.BtnSet) begin
                  sec_q   <= '0;
                  state_q <= RUN;
               end
            end
            AL_H: begin
               if (bus.BtnInc) al_hour_q <= (al_hour_q == 5'd23) ? '0 : al_hour_q + 5'd1;
               if (bus.BtnAlarm) state_q <= AL_M;
            end
            AL_M: begin
               if (bus.BtnInc) al_min_q <= (al_min_q == 6'd59) ? '0 : al_min_q + 6'd1;
               if (bus.BtnAlarm) begin
                  al_on_q <= 1'b1;
                  state_q <= RUN;
               end
            end
            RING: begin
               if (bus.BtnStop || (bus.Tick1Hz && cnt_d == RING_CNT)) begin
                  state_q <= RUN;
                  ring_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
               end else if (bus.BtnInc) begin
                  state_q   <= SNOOZE;
                  ring_q    <= 1'b0;
                  sec_cnt_q <= '0;
`endif
               end else if (bus.Tick1Hz) begin
                  sec_cnt_q <= cnt_d;
               end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
               if (bus.BtnStop) begin
                  state_q <= RUN;
               end else if (bus.Tick1Hz && cnt_d == SNOOZE_CNT) begin
                  state_q   <= RING;
                  ring_q    <= 1'b1;
                  sec_cnt_q <= '0;
               end else if (bus.Tick1Hz) begin
                  sec_cnt_q <= cnt_d;
               end
            end
`endif
            default: begin
               state_q <= RUN;
               ring_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Hour    = hour_q;
   assign bus.Min     = min_q;
   assign bus.Sec     = sec_q;
   assign bus.AlHour  = al_hour_q;
   assign bus.AlMin   = al_min_q;
   assign bus.AlarmOn = al_on_q;
   assign bus.Ringing = ring_q;
   assign bus.State   = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: seconds-of-day reference model, directed scenarios, then random buttons/ticks.
module tb_alarm_ctrl;

   localparam int RING_SECS   = 60;
   localparam int SNOOZE_SECS = 300;
   localparam int M_RUN = 0, M_SET_H = 1, M_SET_M = 2, M_AL_H = 3, M_AL_M = 4, M_RING = 5, M_SNOOZE = 6;

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic [4:0] ah;
      logic [5:0] am;
      logic       on;
      logic       ring;
      logic [2:0] st;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   alarm_ctrl_if bus ();

   alarm_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)) dut (
      .Clk  (clk),
      .Rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: time as seconds of day, alarm as minute of day.
   int   tod, al, mode, left;
   bit   armed;
   exp_t q[$];
   int   checks = 0, failures = 0;

   function automatic exp_t snapshot();
      exp_t e;
      e.h    = 5'(tod / 3600);
      e.m    = 6'((tod / 60) % 60);
      e.s    = 6'(tod % 60);
      e.ah   = 5'(al / 60);
      e.am   = 6'(al % 60);
      e.on   = armed;
      e.ring = (mode == M_RING);
      e.st   = 3'(mode);
      return e;
   endfunction

   task automatic step(input bit tk, input bit st, input bit ab, input bit ic, input bit sp, input bit rn);
      @(negedge clk);
      bus.Tick1Hz  = tk;
      bus.BtnSet   = st;
      bus.BtnAlarm = ab;
      bus.BtnInc   = ic;
      bus.BtnStop  = sp;
      rst_n        = rn;
      if (!rn) begin
         tod = 0; al = 0; armed = 0; mode = M_RUN; left = 0;
      end else begin
         if (tk && mode != M_SET_H && mode != M_SET_M) tod = (tod + 1) % 86400;
         case (mode)
            M_RUN: begin
               if (tk && armed && tod == al * 60) begin
                  mode = M_RING; left = RING_SECS;
               end else if (st) mode = M_SET_H;
               else if (ab) mode = M_AL_H;
               else if (sp) armed = !armed;
            end
            M_SET_H: begin
               if (ic) tod = (((tod / 3600) + 1) % 24) * 3600 + tod % 3600;
               if (st) mode = M_SET_M;
            end
            M_SET_M: begin
               if (ic) tod = (tod / 3600) * 3600 + ((((tod / 60) % 60) + 1) % 60) * 60 + tod % 60;
               if (st) begin tod = tod - tod % 60; mode = M_RUN; end
            end
            M_AL_H: begin
               if (ic) al = (((al / 60) + 1) % 24) * 60 + al % 60;
               if (ab) mode = M_AL_M;
            end
            M_AL_M: begin
               if (ic) al = (al / 60) * 60 + ((al % 60) + 1) % 60;
               if (ab) begin armed = 1; mode = M_RUN; end
            end
            M_RING: begin
               if (sp) mode = M_RUN;
               else if (tk && left == 1) mode = M_RUN;
`ifdef ALARM_SNOOZE_EN
               else if (ic) begin mode = M_SNOOZE; left = SNOOZE_SECS; end
`endif
               else if (tk) left = left - 1;
            end
            M_SNOOZE: begin
               if (sp) mode = M_RUN;
               else if (tk && left == 1) begin mode = M_RING; left = RING_SECS; end
               else if (tk) left = left - 1;
            end
            default: mode = M_RUN;
         endcase
      end
      q.push_back(snapshot());
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 1);
   endtask

   task automatic ticks(input int n);
      repeat (n) step(1, 0, 0, 0, 0, 1);
   endtask

   // From RUN: set the clock one minute before the alarm, then tick into it.
   task automatic ring_at_alarm(input bit set_on_match);
      int ah, tgt_m;
      ah    = al / 60;
      tgt_m = ((al % 60) + 59) % 60;
      step(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 24 && tod / 3600 != ah; i++) step(0, 0, 0, 1, 0, 1);
      step(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 60 && (tod / 60) % 60 != tgt_m; i++) step(0, 0, 0, 1, 0, 1);
      step(0, 1, 0, 0, 0, 1);
      ticks(59);
      step(1, set_on_match, 0, 0, 0, 1);
   endtask

   // Monitor: one registered snapshot per clock, compared just after the edge.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '{bus.Hour, bus.Min, bus.Sec, bus.AlHour, bus.AlMin, bus.AlarmOn, bus.Ringing, bus.State};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL outputs @%0t: got %0d:%0d:%0d al=%0d:%0d on=%0b ring=%0b st=%0d, want %0d:%0d:%0d al=%0d:%0d on=%0b ring=%0b st=%0d",
                        $time, a.h, a.m, a.s, a.ah, a.am, a.on, a.ring, a.st,
                        e.h, e.m, e.s, e.ah, e.am, e.on, e.ring, e.st);
            end
         end
      end
   end

   initial begin
      int r;
      bus.Tick1Hz = 0; bus.BtnSet = 0; bus.BtnAlarm = 0; bus.BtnInc = 0; bus.BtnStop = 0;
      rst_n = 0;
      tod = 0; al = 0; armed = 0; mode = M_RUN; left = 0;

      step(1, 1, 1, 1, 1, 0);            // reset overrides all inputs
      step(0, 0, 0, 0, 0, 0);
      idle(2);

      step(0, 1, 1, 0, 0, 1);            // BtnSet wins over BtnAlarm -> SET_H
      ticks(10);                         // paused in SET_H
      repeat (25) step(0, 0, 0, 1, 0, 1);
      repeat (22) step(0, 0, 0, 1, 0, 1);
      step(0, 1, 0, 0, 0, 1);
      repeat (59) step(0, 0, 0, 1, 0, 1);
      step(0, 1, 0, 0, 0, 1);            // 23:59:00, RUN
      ticks(59);
      step(1, 0, 0, 0, 0, 1);            // -> 00:00:00
      idle(2);

      step(0, 0, 1, 0, 0, 1);            // alarm set 07:30
      repeat (7) step(0, 0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 0, 1);
      repeat (30) step(0, 0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 0, 1);
      ring_at_alarm(0);                  // fires at 07:30:00
      ticks(RING_SECS);                  // auto-stop
      idle(2);

      ring_at_alarm(1);                  // match beats BtnSet
      step(0, 0, 0, 1, 0, 1);            // snooze or ignored, by build
      ticks(3);
      step(0, 0, 0, 0, 1, 1);            // BtnStop -> RUN, still armed
      idle(2);
`ifdef ALARM_SNOOZE_EN
      ring_at_alarm(0);
      step(0, 0, 0, 1, 0, 1);
      ticks(SNOOZE_SECS);
      step(0, 0, 0, 0, 1, 1);
      idle(2);
`endif

      ring_at_alarm(0);
      ticks(4);
      step(1, 0, 0, 0, 0, 0);            // reset mid-ring
      idle(3);

      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 15);
         step($urandom_range(0, 1) == 1, r == 0, r == 1, r == 2 || r == 3, r == 4,
              $urandom_range(0, 499) != 0);
      end
      idle(2);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expected snapshots left, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SECS, default 60: seconds the alarm rings before auto-stop (1..511).
REQ-002 Parameter SNOOZE_SECS, default 300: snooze length in seconds (1..511).
REQ-003 Clk  input  1  system clock; all state on posedge Clk.
REQ-004 Rst_n  input  1  reset; synchronous, active-low.
REQ-005 Tick1Hz  input  1  one-cycle enable pulse, once per second, from the clock divider.
REQ-006 BtnSet  input  1  one-cycle pulse; enter/advance time-set mode.
REQ-007 BtnAlarm  input  1  one-cycle pulse; enter/advance alarm-set mode.
REQ-008 BtnInc  input  1  one-cycle pulse; increment the selected field, or snooze while ringing.
REQ-009 BtnStop  input  1  one-cycle pulse; stop ringing, or toggle AlarmOn in RUN.
REQ-010 Hour  output  5  current hour, 0..23.
REQ-011 Min  output  6  current minute, 0..59.
REQ-012 Sec  output  6  current second, 0..59.
REQ-013 AlHour / AlMin  output  5 / 6  alarm time.
REQ-014 AlarmOn  output  1  alarm armed.
REQ-015 Ringing  output  1  high while in RING.
REQ-016 State  output  3  FSM state code: RUN=0, SET_H=1, SET_M=2, AL_H=3, AL_M=4, RING=5, SNOOZE=6.

Function
REQ-017 Timekeeping shall advance Sec on each Tick1Hz in RUN, RING and SNOOZE, carrying 59->0 into Min and Min 59->0 into Hour; Hour wraps 23->0.
REQ-018 In SET_H and SET_M, Tick1Hz shall be ignored: the clock is paused.
REQ-019 RUN: BtnSet->SET_H; else BtnAlarm->AL_H; else BtnStop toggles AlarmOn; BtnSet wins over BtnAlarm.
REQ-020 RUN alarm match: AlarmOn=1 and, after the tick update, Hour==AlHour, Min==AlMin, Sec==0 -> RING in the next cycle.
REQ-021 An alarm match shall take priority over any button pulse in the same cycle.
REQ-022 SET_H: BtnInc -> Hour=(Hour+1) mod 24; BtnSet -> SET_M.
REQ-023 SET_M: BtnInc -> Min=(Min+1) mod 60, with no carry into Hour; BtnSet -> Sec=0 and go to RUN.
REQ-024 AL_H / AL_M: behave as SET_H / SET_M on AlHour / AlMin, advanced by BtnAlarm.
REQ-025 Leaving AL_M shall set AlarmOn=1.
REQ-026 Timekeeping continues in AL_H and AL_M.
REQ-027 Entering RING shall clear the 9-bit second counter SecCnt; each Tick1Hz increments it.
REQ-028 RING exits: SecCnt reaching RING_SECS -> RUN; BtnStop -> RUN with AlarmOn unchanged; BtnInc -> SNOOZE (config-dependent, see REQ-033).
REQ-029 SNOOZE: SecCnt is cleared on entry and counts ticks; reaching SNOOZE_SECS -> RING; BtnStop -> RUN.
REQ-030 Outputs shall be registered; button effects are visible one cycle after the pulse.

Reset
REQ-031 When Rst_n=0 at a posedge Clk, the block shall set State=RUN, Hour/Min/Sec=0, AlHour/AlMin=0, AlarmOn=0, Ringing=0 and SecCnt=0; this reset overrides all inputs.
REQ-032 Reset asserted mid-RING or mid-SNOOZE shall drop Ringing in the same edge, with no pending re-ring.

Configuration
REQ-033 Macro ALARM_SNOOZE_EN: when defined, the SNOOZE state and REQ-029 are present; when undefined, BtnInc in RING is ignored, SNOOZE is unreachable and its logic is absent.

Verification
REQ-034 Time wrap: set 23:59, 59 ticks from Sec=0 then 1 tick -> 00:00:00.
REQ-035 Alarm fires: AlHour=07, AlMin=30, AlarmOn=1; time 07:29:59 + tick -> Ringing=1 next cycle. After RING_SECS=60 ticks -> Ringing=0, State=0.
REQ-036 Priority: BtnSet on the same cycle as a matching tick -> State=5, not 1. BtnSet+BtnAlarm together in RUN -> State=1.
REQ-037 Snooze (ALARM_SNOOZE_EN defined): BtnInc in RING -> State=6, Ringing=0; after 300 ticks -> State=5. Rebuild without the macro: BtnInc in RING -> State stays 5.
REQ-038 Set-mode pause: in SET_H, 10 ticks -> Sec unchanged. BtnInc x25 from Hour=0 -> Hour=1.
REQ-039 Reset mid-ring: Rst_n=0 for 1 cycle while State=5 -> all outputs 0, State=0 on the next cycle.
